// File: rtl/me_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : me_search_ctrl
// Description : Sequencer for the motion-estimation absolute-difference (AD)
//               accumulation array. It walks the current block pixel by pixel
//               for each batch of candidates and owns the partial-SAD
//               registers that feed the AD array and capture its result. After
//               each batch it scans the batch SADs lane by lane and keeps a
//               running minimum. On completion it pulses o_done with the best
//               SAD and its global candidate index.
// Revision    : 1.0 - initial release
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   i_start         begin a search (sampled only while idle)
//   o_busy          high from the cycle after start until DONE exits
//   o_done          one-cycle pulse, results valid
//   o_fetch_req     high while accumulating; requests pixel o_cur_addr and
//                   the reference row of batch o_batch_idx on the AD inputs
//   i_fetch_valid   AD inputs hold valid data this cycle
//   o_cur_addr      current-block pixel index
//   o_batch_idx     current batch
//   o_psad_to_ad    registered per-lane accumulator driven to the AD array
//                   (lane i at bits [(i+1)*PSAD_BITS-1 : i*PSAD_BITS])
//   i_psad_from_ad  AD array psad result, same packing
//   o_best_sad      minimum SAD found
//   o_best_index    global candidate index = batch*PIXELS_IN_BATCH + lane
//
// Build option
//   ME_PSAD_SATURATE_EN : when defined, a lane whose AD add carries out of
//                         PSAD_BITS is clamped to all-ones for the rest of the
//                         batch. Otherwise lanes wrap modulo 2^PSAD_BITS.
// ============================================================================
module me_search_ctrl #(
    parameter int PIXELS_IN_BATCH = 16,
    parameter int BIT_DEPTH       = 8,
    parameter int PSAD_BITS       = 11,
    parameter int BLOCK_PIXELS    = 8,
    parameter int NUM_BATCHES     = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          i_start,
    output logic                                          o_busy,
    output logic                                          o_done,
    output logic                                          o_fetch_req,
    input  logic                                          i_fetch_valid,
    output logic [$clog2(BLOCK_PIXELS)-1:0]               o_cur_addr,
    output logic [$clog2(NUM_BATCHES)-1:0]                o_batch_idx,
    output logic [PSAD_BITS*PIXELS_IN_BATCH-1:0]          o_psad_to_ad,
    input  logic [PSAD_BITS*PIXELS_IN_BATCH-1:0]          i_psad_from_ad,
    output logic [PSAD_BITS-1:0]                          o_best_sad,
    output logic [$clog2(PIXELS_IN_BATCH*NUM_BATCHES)-1:0] o_best_index
);

    localparam int c_ADDR_W  = $clog2(BLOCK_PIXELS);
    localparam int c_BATCH_W = $clog2(NUM_BATCHES);
    localparam int c_LANE_W  = $clog2(PIXELS_IN_BATCH);
    localparam int c_IDX_W   = $clog2(PIXELS_IN_BATCH*NUM_BATCHES);
    localparam int c_ACC_W   = PSAD_BITS*PIXELS_IN_BATCH;

    // A lane can only carry out if a full block of maximum differences
    // exceeds the lane width; otherwise clamping logic is never needed.
    localparam bit c_CAN_OVF =
        (BLOCK_PIXELS * ((1 << BIT_DEPTH) - 1)) >= (1 << PSAD_BITS);

`ifdef ME_PSAD_SATURATE_EN
    localparam bit c_SAT_EN = 1'b1;
`else
    localparam bit c_SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [c_ACC_W-1:0]     r_acc;
    logic [c_ACC_W-1:0]     w_acc_next;
    logic [c_ADDR_W-1:0]    r_addr;
    logic [c_BATCH_W-1:0]   r_batch;
    logic [c_LANE_W-1:0]    r_k;
    logic [PSAD_BITS-1:0]   r_best_sad;
    logic [c_IDX_W-1:0]     r_best_idx;

    logic                   w_accept;
    logic                   w_last_pixel;
    logic                   w_last_lane;
    logic                   w_last_batch;
    logic [PSAD_BITS-1:0]   w_lane_sad;
    logic [c_IDX_W-1:0]     w_cand_idx;

    assign w_accept     = (r_state == S_ACCUM) && i_fetch_valid;
    assign w_last_pixel = (r_addr  == c_ADDR_W'(BLOCK_PIXELS-1));
    assign w_last_lane  = (r_k     == c_LANE_W'(PIXELS_IN_BATCH-1));
    assign w_last_batch = (r_batch == c_BATCH_W'(NUM_BATCHES-1));
    assign w_lane_sad   = r_acc[r_k*PSAD_BITS +: PSAD_BITS];
    assign w_cand_idx   = c_IDX_W'(r_batch) * c_IDX_W'(PIXELS_IN_BATCH)
                        + c_IDX_W'(r_k);

    // ------------------------------------------------------------------
    // Per-lane capture of the AD result
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < PIXELS_IN_BATCH; gi++) begin : g_lane
        if (c_SAT_EN && c_CAN_OVF) begin : g_sat
            logic [PSAD_BITS-1:0] w_old;
            logic [PSAD_BITS-1:0] w_new;
            assign w_old = r_acc[gi*PSAD_BITS +: PSAD_BITS];
            assign w_new = i_psad_from_ad[gi*PSAD_BITS +: PSAD_BITS];
            // A wrapped sum is smaller than what went in; an already
            // clamped lane stays clamped until the batch clears.
            assign w_acc_next[gi*PSAD_BITS +: PSAD_BITS] =
                ((w_old == '1) || (w_new < w_old)) ? '1 : w_new;
        end else begin : g_pass
            assign w_acc_next[gi*PSAD_BITS +: PSAD_BITS] =
                i_psad_from_ad[gi*PSAD_BITS +: PSAD_BITS];
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_fetch_req  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: begin
                o_busy      = 1'b1;
                o_fetch_req = 1'b1;
                if (w_accept && w_last_pixel) begin
                    w_next_state = S_COMPARE;
                end
            end
            S_COMPARE: begin
                o_busy = 1'b1;
                if (w_last_lane) begin
                    w_next_state = w_last_batch ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: accumulator, counters and running minimum
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_addr     <= '0;
            r_batch    <= '0;
            r_k        <= '0;
            r_best_sad <= '1;
            r_best_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_acc   <= '0;
                    r_addr  <= '0;
                    r_batch <= '0;
                    r_k     <= '0;
                    // Previous results stay visible until a new search.
                    if (i_start) begin
                        r_best_sad <= '1;
                        r_best_idx <= '0;
                    end
                end
                S_ACCUM: begin
                    if (i_fetch_valid) begin
                        r_acc  <= w_acc_next;
                        r_addr <= w_last_pixel ? '0 : r_addr + c_ADDR_W'(1);
                    end
                end
                S_COMPARE: begin
                    // Strict compare: on a tie the earlier candidate wins.
                    if (w_lane_sad < r_best_sad) begin
                        r_best_sad <= w_lane_sad;
                        r_best_idx <= w_cand_idx;
                    end
                    if (w_last_lane) begin
                        r_k <= '0;
                        if (!w_last_batch) begin
                            r_batch <= r_batch + c_BATCH_W'(1);
                            r_acc   <= '0;
                        end
                    end else begin
                        r_k <= r_k + c_LANE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_cur_addr   = r_addr;
    assign o_batch_idx  = r_batch;
    assign o_psad_to_ad = r_acc;
    assign o_best_sad   = r_best_sad;
    assign o_best_index = r_best_idx;

endmodule
`default_nettype wire
